// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// master drives the request side, slave (the subtractor) drives status and results.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout, ovf
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout, ovf
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, one full-subtractor cell, LSB first; results and a done pulse after WIDTH cycles.
// No backpressure: start is only sampled while idle, and requests arriving during a run are dropped.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   serial_subtractor_if.slave  bus
);
   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   ar_q, br_q;
   logic [WIDTH-2:0]   dr_q;
   logic               borrow_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               a_msb_q, b_msb_q;
   logic               busy_q, done_q, bout_q, ovf_q;
   logic [WIDTH-1:0]   diff_q;

   logic               d_bit;
   logic               borrow_d;
   logic [WIDTH-1:0]   shift_d;

   assign d_bit    = ar_q[0] ^ br_q[0] ^ borrow_q;
   assign borrow_d = (~ar_q[0] & br_q[0]) | (~(ar_q[0] ^ br_q[0]) & borrow_q);
   // Bit 0 of shift_d is the oldest result bit; it only matters on the final cycle.
   assign shift_d  = {d_bit, dr_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         ar_q     <= '0;
         br_q     <= '0;
         dr_q     <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  ar_q     <= bus.a;
                  br_q     <= bus.b;
                  borrow_q <= bus.bin;
                  a_msb_q  <= bus.a[WIDTH-1];
                  b_msb_q  <= bus.b[WIDTH-1];
                  dr_q     <= '0;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               ar_q     <= ar_q >> 1;
               br_q     <= br_q >> 1;
               dr_q     <= shift_d[WIDTH-1:1];
               borrow_q <= borrow_d;
               if (cnt_q == LAST) begin
                  cnt_q   <= '0;
                  diff_q  <= shift_d;
                  bout_q  <= borrow_d;
                  ovf_q   <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
   assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;
   localparam int W = 8;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {ovf, bout, diff} from plain integer arithmetic
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
      int ua, ub, sa, sb, r, s;
      logic [7:0] d;
      logic bo, ov;
      ua = int'(a);
      ub = int'(b);
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      r  = ua - ub - int'(bin);
      d  = 8'((r + 512) % 256);
      bo = (ua < ub + int'(bin));
      s  = sa - sb - int'(bin);
      ov = (s < -128) || (s > 127);
      return {ov, bo, d};
   endfunction

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin, input string name);
      logic [9:0] exp;
      int lat, busy_cnt;
      exp = model(a, b, bin);
      @(negedge clk);
      bus.start = 1'b1; bus.a = a; bus.b = b; bus.bin = bin;
      @(negedge clk);
      bus.start = 1'b0; bus.a = ~a; bus.b = ~b; bus.bin = ~bin;
      lat = 0; busy_cnt = 0;
      while (!bus.done && lat < 40) begin
         if (bus.busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      n_checks++;
      if (lat !== 8) begin n_fail++; $display("FAIL %s latency: got %0d want 8", name, lat); end
      n_checks++;
      if (busy_cnt !== 8) begin n_fail++; $display("FAIL %s busy_cycles: got %0d want 8", name, busy_cnt); end
      n_checks++;
      if ({bus.ovf, bus.bout, bus.diff} !== exp)
         begin n_fail++; $display("FAIL %s result: got ovf=%b bout=%b diff=%h want ovf=%b bout=%b diff=%h",
            name, bus.ovf, bus.bout, bus.diff, exp[9], exp[8], exp[7:0]); end
      @(negedge clk);
      n_checks++;
      if ({bus.done, bus.busy, bus.ovf, bus.bout, bus.diff} !== {2'b00, exp})
         begin n_fail++; $display("FAIL %s hold: got done=%b busy=%b diff=%h want done=0 busy=0 diff=%h",
            name, bus.done, bus.busy, bus.diff, exp[7:0]); end
   endtask

   task automatic test_reset;
      rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.done, bus.bout, bus.ovf, bus.diff} !== 12'h000)
         begin n_fail++; $display("FAIL reset_values: got busy=%b done=%b bout=%b ovf=%b diff=%h want all 0",
            bus.busy, bus.done, bus.bout, bus.ovf, bus.diff); end
      rst = 1'b0;
   endtask

   task automatic test_directed;
      run_op(8'h35, 8'h12, 1'b0, "basic");
      run_op(8'h00, 8'h01, 1'b0, "underflow");
      run_op(8'hFF, 8'hFF, 1'b1, "bin_wrap");
      run_op(8'h80, 8'h01, 1'b0, "ovf_neg");
      run_op(8'h7F, 8'hFF, 1'b0, "ovf_pos");
      run_op(8'h10, 8'h0F, 1'b1, "zero_bin");
   endtask

   task automatic test_ignore_start;
      int lat;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'h35; bus.b = 8'h12; bus.bin = 1'b0;
      @(negedge clk);
      bus.start = 1'b0; lat = 0;
      @(negedge clk); lat++;
      @(negedge clk); lat++;
      bus.start = 1'b1; bus.a = 8'h99; bus.b = 8'h11;
      @(negedge clk); lat++;
      bus.start = 1'b0;
      while (!bus.done && lat < 40) begin @(negedge clk); lat++; end
      n_checks++;
      if (lat !== 8) begin n_fail++; $display("FAIL ignore_latency: got %0d want 8", lat); end
      n_checks++;
      if (bus.diff !== 8'h23) begin n_fail++; $display("FAIL ignore_result: got %h want 23", bus.diff); end
      bus.start = 1'b1; bus.a = 8'h99; bus.b = 8'h11; bus.bin = 1'b0;
      @(negedge clk);
      bus.start = 1'b0; lat = 0;
      n_checks++;
      if ({bus.busy, bus.done} !== 2'b10)
         begin n_fail++; $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", bus.busy, bus.done); end
      while (!bus.done && lat < 40) begin @(negedge clk); lat++; end
      n_checks++;
      if (lat !== 8) begin n_fail++; $display("FAIL b2b_latency: got %0d want 8", lat); end
      n_checks++;
      if ({bus.bout, bus.diff} !== {1'b0, 8'h88})
         begin n_fail++; $display("FAIL b2b_result: got bout=%b diff=%h want bout=0 diff=88", bus.bout, bus.diff); end
   endtask

   task automatic test_reset_mid;
      int seen;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h33; bus.bin = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.diff} !== {1'b1, 8'h88})
         begin n_fail++; $display("FAIL run_hold: got busy=%b diff=%h want busy=1 diff=88", bus.busy, bus.diff); end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.bout, bus.ovf, bus.diff} !== 12'h000)
         begin n_fail++; $display("FAIL async_reset: got busy=%b done=%b diff=%h want all 0", bus.busy, bus.done, bus.diff); end
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (12) begin @(negedge clk); if (bus.done || bus.busy) seen++; end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL abandon: got %0d active cycles want 0", seen); end
      run_op(8'h05, 8'h03, 1'b0, "after_reset");
   endtask

   task automatic test_reset_done;
      int lat;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'h80; bus.b = 8'h01; bus.bin = 1'b0;
      @(negedge clk);
      bus.start = 1'b0; lat = 0;
      while (!bus.done && lat < 40) begin @(negedge clk); lat++; end
      n_checks++;
      if ({bus.done, bus.ovf, bus.diff} !== {2'b11, 8'h7F})
         begin n_fail++; $display("FAIL pre_reset_done: got done=%b ovf=%b diff=%h want 1 1 7f", bus.done, bus.ovf, bus.diff); end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.done, bus.ovf, bus.bout, bus.diff} !== 11'h000)
         begin n_fail++; $display("FAIL reset_in_done: got done=%b ovf=%b diff=%h want all 0", bus.done, bus.ovf, bus.diff); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_random;
      logic [7:0] a, b;
      logic bin;
      for (int i = 0; i < 24; i++) begin
         a   = 8'($urandom_range(0, 255));
         b   = 8'($urandom_range(0, 255));
         bin = 1'($urandom_range(0, 1));
         run_op(a, b, bin, $sformatf("rand%0d", i));
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset;
      test_directed;
      test_ignore_start;
      test_reset_mid;
      test_reset_done;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
